// File: rtl/capture_pkg.sv
// capture_pkg: shared constants and types for the capture arbiter slice.
// Holds default channel count / data width, the output FSM state encoding
// and a small wrap-around increment helper used for the round-robin pointer.
package capture_pkg;

    localparam int DEF_NUM_CH  = 4;
    localparam int DEF_WIDTH   = 32;
    localparam int DEF_CH_BITS = 2;

    // Output FSM state, kept as plain constants for legacy tool flows
    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE    = 1'b0;
    localparam state_t ST_PRESENT = 1'b1;

    // Channel index at the default channel count
    typedef logic [DEF_CH_BITS-1:0] ch_idx_t;

    // idx + 1, wrapping to 0 at n
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin picker.
// Scans the request vector starting at ptr and wrapping around; the first
// requester found gets a one-hot grant and its index. any is high when at
// least one request is present.
module rr_arbiter #(
    parameter int NUM_CH  = 4,
    parameter int CH_BITS = 2
) (
    input  logic [NUM_CH-1:0]  req,
    input  logic [CH_BITS-1:0] ptr,
    output logic [NUM_CH-1:0]  grant,
    output logic [CH_BITS-1:0] idx,
    output logic               any
);

    logic found;

    // First requester at or after the pointer, in circular order
    always_comb begin
        found = 1'b0;
        grant = '0;
        idx   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            int c;
            c = (int'(ptr) + k) % NUM_CH;
            if (!found && req[c]) begin
                found    = 1'b1;
                grant[c] = 1'b1;
                idx      = CH_BITS'(c);
            end
        end
        any = found;
    end

endmodule

// File: rtl/capture_arbiter.sv
// capture_arbiter: serialises completed centre measurements from NUM_CH
// capture channels onto one valid/ack stream.
//
// Each rising edge of ch_ready[i] (while en is high) latches ch_center[i]
// into a per-channel slot and marks it pending. Pending slots are handed
// out round-robin; the output word is held until out_ack. A new result
// arriving while the slot is still pending sets the sticky overflow bit.
//
// Build option: define CAPTURE_ARB_KEEP_OLDEST_EN to keep the older pending
// value on overflow (new result dropped). Without it the newer result
// replaces the pending value.
module capture_arbiter
    import capture_pkg::*;
#(
    parameter int NUM_CH  = DEF_NUM_CH,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int CH_BITS = DEF_CH_BITS
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [NUM_CH*WIDTH-1:0] ch_center,
    input  logic [NUM_CH-1:0]       ch_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [CH_BITS-1:0]      out_ch,
    output logic                    out_valid,
    input  logic                    out_ack,
    output logic [NUM_CH-1:0]       overflow,
    input  logic                    clr_overflow
);

`ifdef CAPTURE_ARB_KEEP_OLDEST_EN
    localparam bit KEEP_OLDEST = 1'b1;
`else
    localparam bit KEEP_OLDEST = 1'b0;
`endif

    state_t               state;
    logic [NUM_CH-1:0]    ready_d;
    logic [NUM_CH-1:0]    pending;
    logic [WIDTH-1:0]     slot [NUM_CH];
    logic [CH_BITS-1:0]   rr_ptr;

    logic [NUM_CH-1:0]    new_res;
    logic [NUM_CH-1:0]    take;
    logic [NUM_CH-1:0]    ovf_set;
    logic [NUM_CH-1:0]    grant;
    logic [CH_BITS-1:0]   grant_idx;
    logic                 grant_any;
    logic                 xfer;
    logic                 load;
    logic [CH_BITS-1:0]   next_ptr;
    logic [CH_BITS-1:0]   search_ptr;

    assign out_valid = (state == ST_PRESENT);
    assign xfer      = out_valid && out_ack;

    // Pointer just past the channel currently being accepted
    assign next_ptr  = CH_BITS'(wrap_inc(int'(out_ch), NUM_CH));

    // When a word is being accepted, search from just past it so the same
    // channel cannot win again while others wait.
    assign search_ptr = xfer ? next_ptr : rr_ptr;

    // A new word is loaded from idle, or back-to-back on an accepted word
    assign load = grant_any && ((state == ST_IDLE) || xfer);
    assign take = load ? grant : '0;

    // Rising-edge detect and overflow qualification per channel
    always_comb begin
        new_res = ch_ready & ~ready_d & {NUM_CH{en}};
        ovf_set = new_res & pending & ~take;
    end

    rr_arbiter #(
        .NUM_CH  (NUM_CH),
        .CH_BITS (CH_BITS)
    ) u_rr_arbiter (
        .req   (pending),
        .ptr   (search_ptr),
        .grant (grant),
        .idx   (grant_idx),
        .any   (grant_any)
    );

    // Edge detect history, pending slots and sticky overflow flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_d  <= '0;
            pending  <= '0;
            overflow <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                slot[i] <= '0;
            end
        end else begin
            ready_d <= ch_ready;
            for (int i = 0; i < NUM_CH; i++) begin
                // Slot being emptied or already empty always takes the new
                // value; an occupied slot only if freshest-wins is built.
                if (new_res[i] && (!pending[i] || take[i] || !KEEP_OLDEST)) begin
                    slot[i] <= ch_center[i*WIDTH +: WIDTH];
                end
            end
            pending  <= (pending & ~take) | new_res;
            overflow <= (clr_overflow ? '0 : overflow) | ovf_set;
        end
    end

    // Output FSM: present one word at a time, hold until accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            out_data <= '0;
            out_ch   <= '0;
            rr_ptr   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (load) begin
                        out_data <= slot[grant_idx];
                        out_ch   <= grant_idx;
                        state    <= ST_PRESENT;
                    end
                end
                ST_PRESENT: begin
                    if (xfer) begin
                        rr_ptr <= next_ptr;
                        if (load) begin
                            out_data <= slot[grant_idx];
                            out_ch   <= grant_idx;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_capture_arbiter.sv
// tb_capture_arbiter: directed-vector bench for capture_arbiter with
// hand-computed expected values. Honours CAPTURE_ARB_KEEP_OLDEST_EN for the
// overflow data check.
module tb_capture_arbiter;

    localparam int NUM_CH  = 4;
    localparam int WIDTH   = 32;
    localparam int CH_BITS = 2;

    logic                    clk;
    logic                    rst_n;
    logic                    en;
    logic [NUM_CH*WIDTH-1:0] ch_center;
    logic [NUM_CH-1:0]       ch_ready;
    logic [WIDTH-1:0]        out_data;
    logic [CH_BITS-1:0]      out_ch;
    logic                    out_valid;
    logic                    out_ack;
    logic [NUM_CH-1:0]       overflow;
    logic                    clr_overflow;

    int n_vec;
    int n_miss;

    capture_arbiter #(
        .NUM_CH  (NUM_CH),
        .WIDTH   (WIDTH),
        .CH_BITS (CH_BITS)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .ch_center    (ch_center),
        .ch_ready     (ch_ready),
        .out_data     (out_data),
        .out_ch       (out_ch),
        .out_valid    (out_valid),
        .out_ack      (out_ack),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic step(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_ch(input int ch, input logic [WIDTH-1:0] val);
        ch_center[ch*WIDTH +: WIDTH] = val;
    endtask

    task automatic check_word(input string tag, input int ch, input logic [WIDTH-1:0] val);
        chk_eq({tag, "_valid"}, 64'(out_valid), 64'(1));
        chk_eq({tag, "_ch"},    64'(out_ch),    64'(ch));
        chk_eq({tag, "_data"},  64'(out_data),  64'(val));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);
    endtask

    logic [WIDTH-1:0] exp_ovf_data;
    int               valid_cnt;

    initial begin
        n_vec        = 0;
        n_miss       = 0;
        rst_n        = 1'b0;
        en           = 1'b1;
        ch_center    = '0;
        ch_ready     = '0;
        out_ack      = 1'b1;
        clr_overflow = 1'b0;

        // Reset state
        step(2);
        chk_eq("rst_valid",    64'(out_valid), 64'(0));
        chk_eq("rst_data",     64'(out_data),  64'(0));
        chk_eq("rst_ch",       64'(out_ch),    64'(0));
        chk_eq("rst_overflow", 64'(overflow),  64'(0));
        rst_n = 1'b1;
        step(1);

        // Single result on ch2: valid two edges after ready rises, for one cycle
        set_ch(2, 32'h0000_1000);
        ch_ready[2] = 1'b1;
        step(1);
        chk_eq("single_lat1", 64'(out_valid), 64'(0));
        step(1);
        check_word("single", 2, 32'h0000_1000);
        step(1);
        chk_eq("single_drop", 64'(out_valid), 64'(0));
        ch_ready[2] = 1'b0;
        step(2);

        // Back-pressure: word held stable while not accepted
        out_ack = 1'b0;
        set_ch(0, 32'h0000_0010);
        ch_ready[0] = 1'b1;
        step(2);
        check_word("bp_first", 0, 32'h0000_0010);
        for (int k = 0; k < 20; k++) begin
            step(1);
            check_word("bp_hold", 0, 32'h0000_0010);
        end
        out_ack = 1'b1;
        step(1);
        chk_eq("bp_drop", 64'(out_valid), 64'(0));
        step(3);
        chk_eq("bp_nodup", 64'(out_valid), 64'(0));
        ch_ready[0] = 1'b0;
        step(1);

        // Round-robin from pointer 0
        do_reset();
        for (int c = 0; c < NUM_CH; c++) set_ch(c, 32'hA0 + 32'(c));
        ch_ready = 4'b1111;
        step(2);
        check_word("rr0_a", 0, 32'hA0);
        step(1);
        check_word("rr0_b", 1, 32'hA1);
        step(1);
        check_word("rr0_c", 2, 32'hA2);
        step(1);
        check_word("rr0_d", 3, 32'hA3);
        step(1);
        chk_eq("rr0_end", 64'(out_valid), 64'(0));
        ch_ready = '0;
        step(1);

        // Move pointer to 2 with a single ch1 word
        set_ch(1, 32'hB1);
        ch_ready[1] = 1'b1;
        step(2);
        check_word("ptr_mv", 1, 32'hB1);
        ch_ready[1] = 1'b0;
        step(2);

        // Round-robin from pointer 2
        for (int c = 0; c < NUM_CH; c++) set_ch(c, 32'hC0 + 32'(c));
        ch_ready = 4'b1111;
        step(2);
        check_word("rr2_a", 2, 32'hC2);
        step(1);
        check_word("rr2_b", 3, 32'hC3);
        step(1);
        check_word("rr2_c", 0, 32'hC0);
        step(1);
        check_word("rr2_d", 1, 32'hC1);
        step(1);
        chk_eq("rr2_end", 64'(out_valid), 64'(0));
        ch_ready = '0;
        step(1);

        // Overflow: ch0 occupies output, ch1 fires twice while pending
        out_ack = 1'b0;
        set_ch(0, 32'h77);
        ch_ready[0] = 1'b1;
        step(2);
        check_word("ovf_busy", 0, 32'h77);
        set_ch(1, 32'h55);
        ch_ready[1] = 1'b1;
        step(1);
        chk_eq("ovf_none", 64'(overflow), 64'(0));
        ch_ready[1] = 1'b0;
        step(1);
        set_ch(1, 32'h66);
        ch_ready[1] = 1'b1;
        step(1);
        chk_eq("ovf_set", 64'(overflow), 64'(4'b0010));
        out_ack = 1'b1;
        step(1);
`ifdef CAPTURE_ARB_KEEP_OLDEST_EN
        exp_ovf_data = 32'h55;
`else
        exp_ovf_data = 32'h66;
`endif
        check_word("ovf_word", 1, exp_ovf_data);
        chk_eq("ovf_sticky", 64'(overflow), 64'(4'b0010));
        step(1);
        chk_eq("ovf_idle", 64'(out_valid), 64'(0));
        clr_overflow = 1'b1;
        step(1);
        clr_overflow = 1'b0;
        chk_eq("ovf_clr", 64'(overflow), 64'(0));
        ch_ready = '0;
        step(2);

        // Disable: rising ready ignored, no overflow
        en = 1'b0;
        set_ch(3, 32'h33);
        ch_ready[3] = 1'b1;
        valid_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            step(1);
            if (out_valid) valid_cnt++;
        end
        chk_eq("dis_nout", 64'(valid_cnt), 64'(0));
        chk_eq("dis_novf", 64'(overflow),  64'(0));
        ch_ready[3] = 1'b0;
        en = 1'b1;
        step(1);
        // Held-high ready yields exactly one word
        ch_ready[3] = 1'b1;
        valid_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            step(1);
            if (out_valid) begin
                valid_cnt++;
                chk_eq("hold_data", 64'(out_data), 64'(32'h33));
            end
        end
        chk_eq("hold_once", 64'(valid_cnt), 64'(1));
        ch_ready[3] = 1'b0;
        step(1);

        // Asynchronous reset mid-word with another channel pending
        out_ack = 1'b0;
        set_ch(2, 32'h22);
        ch_ready[2] = 1'b1;
        step(2);
        check_word("ar_pre", 2, 32'h22);
        set_ch(0, 32'h99);
        ch_ready[0] = 1'b1;
        step(1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_eq("ar_valid", 64'(out_valid), 64'(0));
        chk_eq("ar_data",  64'(out_data),  64'(0));
        ch_ready = '0;
        step(2);
        rst_n   = 1'b1;
        out_ack = 1'b1;
        valid_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            step(1);
            if (out_valid) valid_cnt++;
        end
        chk_eq("ar_nostale", 64'(valid_cnt), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
